// File: rtl/mult_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package mult_ctrl_pkg;

  localparam int DEF_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } mult_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the previous winner.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic [IDX_W-1:0] w_idx;

  // Walk from the lowest-priority slot to the highest so the nearest requester wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_grant) + k) % NREQ);
      if (en && req[w_idx]) begin
        grant = w_idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_shift_add_ctrl.sv
// Shared controller for a shift-add multiplier datapath: arbitrates requesters,
// sequences the datapath strobes and returns the product to the winner.
module mult_shift_add_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_m,
  input  logic [NREQ*2*WIDTH-1:0] req_M,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_R,
  output logic                    busy,
  output logic [WIDTH-1:0]        m,
  output logic [2*WIDTH-1:0]      M,
  output logic                    s1,
  output logic                    en1,
  output logic                    s2,
  output logic                    en2,
  input  logic                    ProxBit_m,
  input  logic [CNT_W-1:0]        CountOut,
  input  logic [2*WIDTH-1:0]      R
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  mult_state_t      r_state;
  mult_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_arb_grant;
  logic             w_arb_any;
  logic [NREQ-1:0]  w_grant_oh;
  logic             w_load;
  logic             w_done;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .en         (r_state == ST_IDLE),
    .grant      (w_arb_grant),
    .any        (w_arb_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_arb_any) r_grant <= w_arb_grant;
      if (r_state == ST_LOAD) r_last_grant <= r_grant;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_any) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_TEST;
      ST_TEST: begin
        if (CountOut == CNT_W'(WIDTH)) w_state_nxt = ST_DONE;
        else if (ProxBit_m)            w_state_nxt = ST_ADD;
        else                           w_state_nxt = ST_SHIFT;
      end
      ST_ADD:   w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = ST_TEST;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore decode; operands are gated to LOAD so reset forces them to zero.
  assign w_load     = (r_state == ST_LOAD);
  assign w_done     = (r_state == ST_DONE);
  assign w_grant_oh = NREQ'(1) << r_grant;

  assign s1        = w_load;
  assign en1       = w_load || (r_state == ST_SHIFT);
  assign s2        = w_load;
  assign en2       = w_load || (r_state == ST_ADD);
  assign busy      = (r_state != ST_IDLE);
  assign req_ready = w_load ? w_grant_oh : '0;
  assign rsp_valid = w_done ? w_grant_oh : '0;
  assign rsp_R     = w_done ? R : '0;
  assign m         = w_load ? req_m[int'(r_grant)*WIDTH +: WIDTH] : '0;
  assign M         = w_load ? req_M[int'(r_grant)*2*WIDTH +: 2*WIDTH] : '0;

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Bench for mult_shift_add_ctrl with a behavioural shift-add datapath and a response scoreboard.
module tb_mult_shift_add_ctrl;
  import mult_ctrl_pkg::*;

  localparam int WIDTH = 3;
  localparam int NREQ  = 2;
  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*WIDTH-1:0] req_m;
  logic [NREQ*PW-1:0]   req_M;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [PW-1:0]        rsp_R;
  logic                 busy;
  logic [WIDTH-1:0]     m;
  logic [PW-1:0]        M;
  logic                 s1, en1, s2, en2;
  logic                 ProxBit_m;
  logic [CNT_W-1:0]     CountOut;
  logic [PW-1:0]        R;

  mult_shift_add_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_m(req_m), .req_M(req_M),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_R(rsp_R), .busy(busy),
    .m(m), .M(M), .s1(s1), .en1(en1), .s2(s2), .en2(en2),
    .ProxBit_m(ProxBit_m), .CountOut(CountOut), .R(R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath (operand shift registers, counter, accumulator)
  logic [WIDTH-1:0] dp_m;
  logic [PW-1:0]    dp_M, dp_R;
  logic [CNT_W-1:0] dp_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_m <= '0; dp_M <= '0; dp_R <= '0; dp_cnt <= '0;
    end else begin
      if (en1) begin
        if (s1) begin dp_m <= m; dp_M <= M; dp_cnt <= '0; end
        else begin dp_m <= dp_m >> 1; dp_M <= dp_M << 1; dp_cnt <= dp_cnt + 1'b1; end
      end
      if (en2) dp_R <= s2 ? '0 : dp_R + dp_M;
    end
  end
  assign ProxBit_m = dp_m[0];
  assign CountOut  = dp_cnt;
  assign R         = dp_R;

  // Requesters must hold req_valid until their req_ready pulse
  logic [NREQ-1:0] pv;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pv <= '0;
    else begin
      for (int i = 0; i < NREQ; i++)
        assert (!(pv[i] && !req_valid[i] && !req_ready[i]))
          else $error("req_valid[%0d] dropped before req_ready", i);
      pv <= req_valid;
    end
  end

  typedef struct { int idx; logic [PW-1:0] r; int pop; int issue; int lat; } exp_t;
  typedef struct { int idx; int issue; bit chk; } rdy_t;
  exp_t rsp_q[$];
  rdy_t rdy_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a ready or response pulse
  int adds = 0;
  initial begin
    rdy_t r;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (en2 && !s2) adds++;
        if (req_ready != '0) begin
          adds = 0;
          if (rdy_q.size() == 0) check("unexpected_ready", 64'(req_ready), 64'(0));
          else begin
            r = rdy_q.pop_front();
            check("ready_idx", 64'(req_ready), 64'(1) << r.idx);
            if (r.chk) check("ready_lat", 64'(cyc - r.issue), 64'(1));
          end
        end
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'(0));
          else begin
            e = rsp_q.pop_front();
            check("rsp_idx", 64'(rsp_valid), 64'(1) << e.idx);
            check("rsp_R", 64'(rsp_R), 64'(e.r));
            check("add_cycles", 64'(adds), 64'(e.pop));
            if (e.lat > 0) check("rsp_latency", 64'(cyc - e.issue), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int idx, input logic [WIDTH-1:0] mv, input logic [PW-1:0] Mv,
                       input logic [PW-1:0] rv, input int pop, input int lat, input bit push_rsp);
    req_m[idx*WIDTH +: WIDTH] = mv;
    req_M[idx*PW +: PW]       = Mv;
    req_valid[idx]            = 1'b1;
    rdy_q.push_back('{idx, cyc, (lat > 0)});
    if (push_rsp) rsp_q.push_back('{idx, rv, pop, cyc, lat});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || busy || req_valid != '0) && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(rsp_q.size()), 64'(0));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({req_ready, rsp_valid, rsp_R, busy, m, M, s1, en1, s2, en2}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    req_valid = '0;
    req_m     = '0;
    req_M     = '0;
    repeat (3) step();
    check_outputs_zero("reset_outputs");
    reset_n = 1'b1;
    step();
    check("idle_busy", 64'(busy), 64'(0));

    // Single multiply, full ones, zero multiplier
    issue(0, 3'b001, 6'b000100, 6'b000100, 1, 10, 1'b1);
    drain("drain_single", 60);
    issue(0, 3'b111, 6'b000111, 6'b110001, 3, 12, 1'b1);
    drain("drain_ones", 60);
    issue(0, 3'b000, 6'b000101, 6'b000000, 0, 9, 1'b1);
    drain("drain_zero", 60);

    // Reset pulsed during ADD aborts the operation
    issue(0, 3'b111, 6'b000111, 6'b110001, 3, 0, 1'b0);
    n = 0;
    while (!(en2 && !s2) && n < 40) begin step(); n++; end
    check("reached_add", 64'(en2 && !s2), 64'(1));
    reset_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_op");
    step();
    reset_n = 1'b1;
    step();
    issue(1, 3'b101, 6'b000011, 6'b001111, 2, 11, 1'b1);
    drain("drain_after_reset", 60);

    // Simultaneous requests: req0 first after req1 was last served
    issue(0, 3'b010, 6'b000101, 6'b001010, 1, 10, 1'b1);
    issue(1, 3'b011, 6'b000110, 6'b010010, 2, 0, 1'b1);
    drain("drain_contend1", 100);
    issue(0, 3'b110, 6'b001001, 6'b110110, 2, 11, 1'b1);
    issue(1, 3'b100, 6'b010000, 6'b000000, 1, 0, 1'b1);
    drain("drain_contend2", 100);

    // req1 arrives while req0 is in service and is held until IDLE
    issue(0, 3'b011, 6'b000101, 6'b001111, 2, 11, 1'b1);
    repeat (3) step();
    issue(1, 3'b111, 6'b111111, 6'b111001, 3, 0, 1'b1);
    drain("drain_late_req", 100);

    check("scoreboard_empty", 64'(rsp_q.size() + rdy_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
